// File: rtl/comparator_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : comparator_seq                                                |
// | Purpose  : Chunk-serial (MSB-first) signed/unsigned comparator with a    |
// |            valid/ready request and result handshake.                     |
// | Options  : COMPARATOR_SEQ_EARLY_EXIT_EN - finish on first differing chunk|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module comparator_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         result,
  output logic         eq,
  output logic         lt
);

  localparam int C_CHUNKS = N / W;
  localparam int C_KW     = (C_CHUNKS > 1) ? $clog2(C_CHUNKS) : 1;
  localparam logic [C_KW-1:0] C_K_TOP = C_KW'(C_CHUNKS - 1);

  if (N % W != 0) begin : g_bad_width
    $fatal(1, "comparator_seq: N must be a multiple of W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [N-1:0]    r_a, r_b;
  logic [2:0]      r_mode;
  logic [C_KW-1:0] r_k;
  logic            r_found, r_eq, r_lt, r_result;

  logic            w_signed_in;
  logic [N-1:0]    w_a_cap, w_b_cap;
  logic [W-1:0]    w_a_chunks [C_CHUNKS];
  logic [W-1:0]    w_b_chunks [C_CHUNKS];
  logic            w_diff, w_chunk_lt, w_last, w_finish;
  logic            w_eq_fin, w_lt_fin, w_result_fin;

  // Flipping the sign bit at capture maps two's complement order onto
  // unsigned order, so the chunk datapath is always unsigned.
  assign w_signed_in = (mode == 3'd2) || (mode == 3'd3);

  always_comb begin
    w_a_cap        = a;
    w_b_cap        = b;
    w_a_cap[N-1]   = a[N-1] ^ w_signed_in;
    w_b_cap[N-1]   = b[N-1] ^ w_signed_in;
  end

  for (genvar gi = 0; gi < C_CHUNKS; gi++) begin : g_chunks
    assign w_a_chunks[gi] = r_a[gi*W +: W];
    assign w_b_chunks[gi] = r_b[gi*W +: W];
  end

  assign w_diff     = (w_a_chunks[r_k] != w_b_chunks[r_k]);
  assign w_chunk_lt = (w_a_chunks[r_k] <  w_b_chunks[r_k]);
  assign w_last     = (r_k == '0);

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  assign w_finish = w_last || w_diff;
`else
  assign w_finish = w_last;
`endif

  // Flags as they stand once this cycle's chunk has been considered.
  assign w_eq_fin = r_found ? r_eq : !w_diff;
  assign w_lt_fin = r_found ? r_lt : (w_diff && w_chunk_lt);

  always_comb begin
    w_result_fin = 1'b0;
    case (r_mode)
      3'd0:       w_result_fin = w_eq_fin;
      3'd1:       w_result_fin = !w_eq_fin;
      3'd2, 3'd4: w_result_fin = w_lt_fin;
      3'd3, 3'd5: w_result_fin = !w_lt_fin;
      default:    w_result_fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_CMP;
      S_CMP:   if (w_finish) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= '0;
      r_k      <= C_K_TOP;
      r_found  <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_result <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= w_a_cap;
            r_b     <= w_b_cap;
            r_mode  <= mode;
            r_k     <= C_K_TOP;
            r_found <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
          end
        end
        S_CMP: begin
          // Only the first decisive chunk (or the final equal one) sets flags.
          if (!r_found && (w_diff || w_last)) begin
            r_found <= 1'b1;
            r_eq    <= !w_diff;
            r_lt    <= w_diff && w_chunk_lt;
          end
          if (w_finish) r_result <= w_result_fin;
          else          r_k      <= r_k - C_KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign eq        = r_eq;
  assign lt        = r_lt;

endmodule
`default_nettype wire

// File: doc/comparator_seq.md
COMPARATOR_SEQ -- requirements
Module: comparator_seq

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter W, default 8, meaning chunk width compared per cycle; N % W == 0 required, else elaboration fatal error.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept request.
REQ-007 SHALL have port a  input  N  operand A.
REQ-008 SHALL have port b  input  N  operand B.
REQ-009 SHALL have port mode  input  3  0=EQ, 1=NE, 2=LT signed, 3=GE signed, 4=LTU, 5=GEU, 6/7 reserved.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  1  comparison outcome for captured mode.
REQ-013 SHALL have ports eq and lt  output  1 each  raw flags: A==B; A<B under captured signedness.

Function
REQ-014 SHALL implement FSM IDLE, CMP, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-015 IDLE: on in_valid at rising edge, SHALL capture a, b, mode, set chunk index k = N/W-1 (MSB chunk), go CMP.
REQ-016 CMP: each cycle SHALL compare chunk k of A vs B unsigned; for signed modes the operand MSB SHALL be inverted before comparison (top chunk only).
REQ-017 First differing chunk (MSB-first) SHALL latch eq=0, lt=(A_chunk<B_chunk); later chunks SHALL NOT alter latched flags.
REQ-018 At k==0 with no difference found, SHALL latch eq=1, lt=0; go DONE after the k==0 compare.
REQ-019 result SHALL be: EQ eq; NE !eq; LT/LTU lt; GE/GEU !lt; reserved modes 0.
REQ-020 Latency: out_valid SHALL rise D edges after the accepting edge, D = chunks examined (see REQ-027); W==N gives D=1.
REQ-021 DONE: result, eq, lt SHALL hold stable until out_valid && out_ready, then go IDLE on that edge.
REQ-022 in_valid during CMP/DONE SHALL be ignored (in_ready=0); no request queuing, no overlap.
REQ-023 Input changes on a/b/mode after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-024 rst asserted SHALL immediately force state IDLE, out_valid=0, result=0, eq=0, lt=0, k=N/W-1.
REQ-025 rst asserted mid-CMP or DONE SHALL abandon the transaction; no out_valid for it.
REQ-026 After rst deasserts, in_ready SHALL be 1 and the first edge with in_valid SHALL be accepted.

Configuration
REQ-027 Macro COMPARATOR_SEQ_EARLY_EXIT_EN: defined, CMP SHALL go DONE on the cycle the first differing chunk is found (D = N/W - k_diff); undefined, CMP SHALL always run all N/W chunks (D = N/W, data-independent latency); results identical in both builds.

Verification (N=32, W=8)
REQ-028 Reset, a=0, b=0, mode EQ -> result=1, eq=1; out_valid 4 edges after accept (both builds).
REQ-029 a=FFFFFFFF, b=00000001, mode LT -> result=1; same with LTU -> result=0; out_valid after 1 edge with EARLY_EXIT_EN, 4 without.
REQ-030 a=7FFFFFFF, b=7FFFFFFE, mode GE -> result=1, lt=0; mode NE -> 1; 4 edges both builds.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b -> result held, in_ready=0, no new capture; out_ready=1 -> IDLE next edge.
REQ-032 Assert rst two cycles into CMP -> out_valid stays 0, in_ready=1 after release; next request a=-2, b=-1, LT -> result=1.
REQ-033 1000 random a, b, mode (incl. reserved) with random out_ready stalls -> every result matches behavioural signed/unsigned model; zero errors reported.
